// File: rtl/onchip_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_arb_pkg
// Brief    : Shared widths and owner encoding for the on-chip RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package onchip_ram_arb_pkg;

   localparam int c_ADDR_W = 14;
   localparam int c_DATA_W = 32;
   localparam int c_BE_W   = c_DATA_W / 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_t;

endpackage
`default_nettype wire

// File: rtl/onchip_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_rr_arbiter
// Brief    : Two-way same-cycle grant with MAX_HOLD-bounded ownership.
//            Optional ARB_LOCK_EN pins ownership while the owner holds lock.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_ram_rr_arbiter
   import onchip_ram_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
`ifdef ARB_LOCK_EN
   input  logic [1:0] lock,
`endif
   output logic [1:0] grant
);

   localparam int                  c_HOLD_W   = $clog2(MAX_HOLD + 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LIM = c_HOLD_W'(MAX_HOLD - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = '1;

   owner_t              r_owner;
   logic                r_last;      // 1 when M1 was granted most recently
   logic [c_HOLD_W-1:0] r_hold_cnt;
   logic                w_locked;
   logic                w_keep;
   owner_t              w_next_owner;

`ifdef ARB_LOCK_EN
   assign w_locked = ((r_owner == OWN_M0) && lock[0] && req[0]) ||
                     ((r_owner == OWN_M1) && lock[1] && req[1]);
`else
   assign w_locked = 1'b0;
`endif

   assign w_keep       = w_locked || (r_hold_cnt < c_HOLD_LIM);
   assign w_next_owner = grant[1] ? OWN_M1 : OWN_M0;

   always_comb begin
      grant = 2'b00;
      if (!reset) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
               if (r_owner == OWN_NONE)
                  grant = r_last ? 2'b01 : 2'b10;
               else
                  grant = ((r_owner == OWN_M0) == w_keep) ? 2'b01 : 2'b10;
            end
            default: grant = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner    <= OWN_NONE;
         r_last     <= 1'b1;
         r_hold_cnt <= '0;
      end else if (grant == 2'b00) begin
         r_owner    <= OWN_NONE;
         r_hold_cnt <= '0;
      end else begin
         r_owner <= w_next_owner;
         r_last  <= grant[1];
         // Count only contested re-grants; saturate so a long lock cannot wrap.
         if ((&req) && (w_next_owner == r_owner)) begin
            if (r_hold_cnt != c_HOLD_MAX)
               r_hold_cnt <= r_hold_cnt + 1'b1;
         end else begin
            r_hold_cnt <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/onchip_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onchip_ram_arbiter
// Brief    : Two Avalon-MM masters sharing one single-port on-chip RAM.
//            Define ARB_LOCK_EN to add m0_lock/m1_lock ownership locking.
// Revision : 1.0 - initial release
// ============================================================================
module onchip_ram_arbiter
   import onchip_ram_arb_pkg::*;
#(
   parameter int ADDR_W   = c_ADDR_W,
   parameter int DATA_W   = c_DATA_W,
   parameter int BE_W     = c_BE_W,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
`ifdef ARB_LOCK_EN
   input  logic              m0_lock,
   input  logic              m1_lock,
`endif
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] ram_address,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata
);

   logic [1:0] w_req;
   logic [1:0] w_grant;
   logic [1:0] r_rd_pend;

   assign w_req = {m1_read | m1_write, m0_read | m0_write};

   onchip_ram_rr_arbiter #(
      .MAX_HOLD (MAX_HOLD)
   ) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (w_req),
`ifdef ARB_LOCK_EN
      .lock  ({m1_lock, m0_lock}),
`endif
      .grant (w_grant)
   );

   // The arbiter already withholds grants in reset, which forces chipselect/write low.
   assign m0_waitrequest = reset | (w_req[0] & ~w_grant[0]);
   assign m1_waitrequest = reset | (w_req[1] & ~w_grant[1]);

   assign ram_address    = w_grant[1] ? m1_address    : m0_address;
   assign ram_byteenable = w_grant[1] ? m1_byteenable : m0_byteenable;
   assign ram_writedata  = w_grant[1] ? m1_writedata  : m0_writedata;
   assign ram_chipselect = |w_grant;
   assign ram_write      = (w_grant[0] & m0_write) | (w_grant[1] & m1_write);
   assign ram_clken      = ~reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_rd_pend <= 2'b00;
      else
         r_rd_pend <= {w_grant[1] & m1_read & ~m1_write,
                       w_grant[0] & m0_read & ~m0_write};
   end

   assign m0_readdatavalid = r_rd_pend[0];
   assign m1_readdatavalid = r_rd_pend[1];
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;

endmodule
`default_nettype wire

// File: tb/tb_onchip_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchip_ram_arbiter
// Brief    : Scoreboard bench with a RAM model; MAX_HOLD=4 and MAX_HOLD=1 DUTs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_lock, m1_lock;
   logic [13:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;

   logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic [13:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect, ram_write, ram_clken;
   logic [31:0] ram_writedata, ram_q;

   logic        h1_m0_waitrequest, h1_m1_waitrequest, h1_m0_rdv, h1_m1_rdv;
   logic [31:0] h1_m0_readdata, h1_m1_readdata, h1_ram_writedata;
   logic [13:0] h1_ram_address;
   logic [3:0]  h1_ram_byteenable;
   logic        h1_ram_chipselect, h1_ram_write, h1_ram_clken;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] mem [0:16383];

   always #5 clk = ~clk;

   onchip_ram_arbiter #(.MAX_HOLD(4)) dut (
      .clk(clk), .reset(reset),
`ifdef ARB_LOCK_EN
      .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_q)
   );

   onchip_ram_arbiter #(.MAX_HOLD(1)) dut_h1 (
      .clk(clk), .reset(reset),
`ifdef ARB_LOCK_EN
      .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(h1_m0_waitrequest),
      .m0_readdata(h1_m0_readdata), .m0_readdatavalid(h1_m0_rdv),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(h1_m1_waitrequest),
      .m1_readdata(h1_m1_readdata), .m1_readdatavalid(h1_m1_rdv),
      .ram_address(h1_ram_address), .ram_byteenable(h1_ram_byteenable),
      .ram_chipselect(h1_ram_chipselect), .ram_write(h1_ram_write),
      .ram_writedata(h1_ram_writedata), .ram_clken(h1_ram_clken), .ram_readdata(32'h0)
   );

   // Single-port RAM model: registered read, byte-enabled write.
   always @(posedge clk) begin
      if (ram_clken && ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         end else begin
            ram_q <= mem[ram_address];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every readdatavalid must match the oldest expectation for that master.
   initial begin
      forever begin
         @(negedge clk);
         if (m0_readdatavalid) begin
            if (q0.size() == 0) begin
               checks++; errors++;
               $display("FAIL m0_unexpected_valid actual=1 required=0");
            end else chk("m0_readdata", m0_readdata, q0.pop_front());
         end
         if (m1_readdatavalid) begin
            if (q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL m1_unexpected_valid actual=1 required=0");
            end else chk("m1_readdata", m1_readdata, q1.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic e0, e1;
      reset = 1'b1; m0_lock = 1'b0; m1_lock = 1'b0;
      m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
      m0_read = 1'b1; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
      m0_writedata = '0; m1_writedata = '0;
      tick();
      @(negedge clk);
      chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
      chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
      chk("rst_cs", 32'(ram_chipselect), 32'd0);
      chk("rst_clken", 32'(ram_clken), 32'd0);
      chk("rst_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
      tick();
      reset = 1'b0; m0_read = 1'b0;

      // M0 full write then read back
      m0_write = 1'b1; m0_address = 14'h0010; m0_writedata = 32'hDEADBEEF;
      @(negedge clk);
      chk("wr_m0_wait", 32'(m0_waitrequest), 32'd0);
      chk("wr_ram_write", 32'(ram_write), 32'd1);
      chk("wr_ram_addr", 32'(ram_address), 32'h10);
      tick();
      m0_write = 1'b0; m0_read = 1'b1;
      @(negedge clk);
      chk("rd_m0_wait", 32'(m0_waitrequest), 32'd0);
      chk("rd_ram_write", 32'(ram_write), 32'd0);
      q0.push_back(32'hDEADBEEF);
      tick();

      // Byte write at the top address, read back through M1
      m0_read = 1'b0; m0_write = 1'b1; m0_address = 14'h3FFF; m0_writedata = 32'h11223344;
      tick();
      m0_byteenable = 4'b0010; m0_writedata = 32'h0000AA00;
      tick();
      m0_write = 1'b0; m0_byteenable = 4'hF;
      m1_read = 1'b1; m1_address = 14'h3FFF;
      @(negedge clk);
      chk("be_m1_wait", 32'(m1_waitrequest), 32'd0);
      q1.push_back(32'h1122AA44);
      tick();
      m1_read = 1'b0;
      tick();

      // Fresh reset, then continuous contention
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m0_read = 1'b1; m0_address = 14'h0010;
      m1_read = 1'b1; m1_address = 14'h3FFF;
      for (int i = 0; i < 16; i++) begin
         e0 = (((i / 4) % 2) == 0);
         e1 = ((i % 2) == 0);
         @(negedge clk);
         chk($sformatf("h4_m0_wait[%0d]", i), 32'(m0_waitrequest), 32'(!e0));
         chk($sformatf("h4_m1_wait[%0d]", i), 32'(m1_waitrequest), 32'(e0));
         chk($sformatf("h1_m0_wait[%0d]", i), 32'(h1_m0_waitrequest), 32'(!e1));
         chk($sformatf("h1_m1_wait[%0d]", i), 32'(h1_m1_waitrequest), 32'(e1));
         if (e0) q0.push_back(32'hDEADBEEF);
         else    q1.push_back(32'h1122AA44);
         tick();
      end
      m0_read = 1'b0; m1_read = 1'b0;
      tick();
      tick();

      // Reset lands while an M1 read is pending: it must be dropped
      m1_read = 1'b1;
      @(negedge clk);
      chk("drop_m1_wait", 32'(m1_waitrequest), 32'd0);
      tick();
      reset = 1'b1; m1_read = 1'b0;
      #1;
      chk("drop_rdv", 32'(m1_readdatavalid), 32'd0);
      chk("drop_cs", 32'(ram_chipselect), 32'd0);
      chk("drop_write", 32'(ram_write), 32'd0);
      chk("drop_clken", 32'(ram_clken), 32'd0);
      chk("drop_waits", 32'({m1_waitrequest, m0_waitrequest}), 32'd3);
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("post_cs", 32'(ram_chipselect), 32'd0);
      chk("post_clken", 32'(ram_clken), 32'd1);
      tick();
      tick();

`ifdef ARB_LOCK_EN
      // M1 takes ownership with lock, then holds it against M0
      m1_read = 1'b1; m1_lock = 1'b1; m1_address = 14'h3FFF;
      q1.push_back(32'h1122AA44);
      tick();
      m0_read = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("lock_m0_wait[%0d]", i), 32'(m0_waitrequest), 32'd1);
         chk($sformatf("lock_m1_wait[%0d]", i), 32'(m1_waitrequest), 32'd0);
         chk($sformatf("lock_h1_m0_wait[%0d]", i), 32'(h1_m0_waitrequest), 32'd1);
         q1.push_back(32'h1122AA44);
         tick();
      end
      m1_lock = 1'b0;
      @(negedge clk);
      chk("unlock_m0_wait", 32'(m0_waitrequest), 32'd0);
      chk("unlock_m1_wait", 32'(m1_waitrequest), 32'd1);
      chk("unlock_h1_m0_wait", 32'(h1_m0_waitrequest), 32'd0);
      q0.push_back(32'hDEADBEEF);
      tick();
      m0_read = 1'b0; m1_read = 1'b0;
`endif

      repeat (3) tick();
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/onchip_ram_arbiter.md
Name: onchip_ram_arbiter

Overview:
Two-master arbiter sharing the 16K x 32 single-port on-chip RAM (14-bit word address, byte enables, 1-cycle read latency, unregistered q). Master 0 is the acquisition/packet-build path and master 1 is the UDP transmit reader. Each master sees an Avalon-MM-style slave with waitrequest and readdatavalid. The block sits between both masters and the RAM's chipselect/write/clken/address/data pins.

Parameters:
ADDR_W, 14, RAM word-address width
DATA_W, 32, data width
BE_W, 4, byte-enable width (DATA_W/8)
MAX_HOLD, 4, max consecutive contended grants to one master before a forced switch (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m0_address  in  ADDR_W  master 0 word address
m0_byteenable  in  BE_W  master 0 byte enables
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_waitrequest  out  1  master 0 stall; hold request stable while high
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 read data valid
m1_* (address, byteenable, read, write, writedata, waitrequest, readdata, readdatavalid)  as m0_*  master 1
ram_address  out  ADDR_W  to RAM address
ram_byteenable  out  BE_W  to RAM byteenable
ram_chipselect  out  1  to RAM chipselect
ram_write  out  1  to RAM write
ram_writedata  out  DATA_W  to RAM writedata
ram_clken  out  1  to RAM clken
ram_readdata  in  DATA_W  from RAM readdata

Behaviour:
- reqX = mX_read | mX_write. If read and write are both high, the access is a write.
- Grant is combinational, issued in the same cycle. mX_waitrequest = reqX & ~grantX. At most one grant per cycle.
- Registered state: owner {NONE,M0,M1}, last (reset M1), hold_cnt [$clog2(MAX_HOLD+1)-1:0], rd_pend[1:0].
- Arbitration:
  - Only one master requesting -> that master is granted.
  - Both requesting, owner=NONE -> grant ~last (round robin; M0 wins first after reset).
  - Both requesting, owner=X -> keep X if hold_cnt < MAX_HOLD-1, else switch to the other master.
  - Neither requesting -> owner<=NONE, hold_cnt<=0.
- hold_cnt:
  - Increments when the owner is re-granted while the other master is requesting.
  - Clears on an owner change or on an uncontested cycle.
  - Saturates and never wraps.
- On every grant: owner<=granted and last<=granted.
- RAM drive: granted master's address/byteenable/writedata are muxed to the RAM. ram_chipselect=1 and ram_write=granted write. With no grant, ram_chipselect=0, ram_write=0, and address/data hold the M0 values (don't-care).
- ram_clken=1 whenever reset is low.
- Read latency: exactly 1 cycle. A granted read in cycle N sets rd_pend[X] and produces mX_readdatavalid=1 in cycle N+1. mX_readdata is wired directly to ram_readdata (both ports). Back-to-back reads from either master give one valid per cycle with no bubble.
- Read-during-write by the other master in the next cycle: readdata reflects the value from cycle N (single port; no hazard).
- Reset asserted (async, including mid-transfer):
  - owner=NONE, last=M1, hold_cnt=0, rd_pend=0.
  - readdatavalid outputs=0 immediately.
  - ram_chipselect=ram_write=ram_clken=0 and both waitrequest=1, all combinationally forced.
  - A pending read is dropped and never signalled.
- Changing a request while waitrequest is high is a master protocol violation; the block grants on current values with no checking.

Optional Feature:
ARB_LOCK_EN:
- Defined: adds m0_lock/m1_lock inputs (1 bit each). While the current owner holds lockX=1 with reqX=1, the grant never switches and hold_cnt is ignored. Used for atomic UDP header read-modify-write. lock from a non-owner is ignored.
- Undefined: the lock ports do not exist and arbitration is purely MAX_HOLD round robin.

Decomposition:
- Package onchip_ram_arb_pkg: ADDR_W/DATA_W/BE_W defaults and the owner encoding constants (OWN_NONE=2'd0, OWN_M0=2'd1, OWN_M1=2'd2).
- One sub-module: onchip_ram_rr_arbiter, holding owner/last/hold_cnt and the grant logic (inputs req[1:0], optional lock[1:0]; output grant[1:0]). The top level holds the mux and rd_pend.

Test Plan:
- M0 writes 0xDEADBEEF to addr 0x0010 with be=4'hF, then reads it -> waitrequest 0 both cycles; readdatavalid one cycle after the read, readdata=0xDEADBEEF.
- Byte write be=4'b0010 with data 0x0000AA00 over 0x11223344 at 0x3FFF -> read returns 0x1122AA44 (top-address boundary).
- Both masters issue continuous reads, MAX_HOLD=4 -> grant pattern M0x4, M1x4, M0x4...; waitrequest high on the loser; each valid is routed only to its issuer.
- MAX_HOLD=1, both request simultaneously from idle after reset -> M0 first, then strict alternation.
- Reset asserted the cycle after a granted M1 read -> m1_readdatavalid never pulses; after release, ram_chipselect=0 until a new request arrives.
- ARB_LOCK_EN: M1 owner holds lock for 10 cycles with M0 requesting -> M1 granted all 10 cycles; M0 is granted the cycle lock drops.
